// File: rtl/unified_mem_arb_if.sv
// Request/response bundle between the CPU fetch/load-store ports and the unified memory.
// Latency: none, signal grouping only.
// Backpressure: requests via valid/ready per port; responses are unconditioned pulses.
interface unified_mem_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_rsp_valid;
    logic [DATA_W-1:0]     i_rdata;
    logic                  i_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ADDR_W-1:0]     d_addr;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_rsp_valid;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_err;

    // CPU side: issues requests, consumes responses.
    modport master (
        output i_req_valid, i_addr,
        output d_req_valid, d_addr, d_we, d_be, d_wdata,
        input  i_req_ready, i_rsp_valid, i_rdata, i_err,
        input  d_req_ready, d_rsp_valid, d_rdata, d_err
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  i_req_valid, i_addr,
        input  d_req_valid, d_addr, d_we, d_be, d_wdata,
        output i_req_ready, i_rsp_valid, i_rdata, i_err,
        output d_req_ready, d_rsp_valid, d_rdata, d_err
    );
endinterface

// File: rtl/unified_mem_arb.sv
// Unified word-organised instruction/data memory shared by fetch and load/store ports via round-robin arbitration.
// Latency: one cycle from grant to a single-cycle response pulse; one request accepted per cycle.
// Backpressure: only the losing port sees ready low and must hold its request; responses cannot be stalled.
module unified_mem_arb #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 64,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    unified_mem_arb_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Address decode: word index plus a legality flag (aligned and inside the array).
    logic [IDX_W-1:0] i_idx;
    logic [IDX_W-1:0] d_idx;
    logic             i_ok;
    logic             d_ok;

    assign i_idx = bus.i_addr[IDX_W+1:2];
    assign d_idx = bus.d_addr[IDX_W+1:2];
    assign i_ok  = (bus.i_addr[1:0] == 2'b00) &&
                   ({2'b00, bus.i_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));
    assign d_ok  = (bus.d_addr[1:0] == 2'b00) &&
                   ({2'b00, bus.d_addr[ADDR_W-1:2]} < ADDR_W'(DEPTH));

    // prio_d names the port that wins the next contention: it is the port
    // that lost the last one, and after reset the data port goes first.
    logic prio_d;
    logic gnt_i;
    logic gnt_d;
    logic contend;

    assign contend = bus.i_req_valid & bus.d_req_valid;

    // Grant at most one port; nothing is granted while reset is asserted.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_n) begin
            if (bus.d_req_valid && (prio_d || !bus.i_req_valid)) begin
                gnt_d = 1'b1;
            end else if (bus.i_req_valid) begin
                gnt_i = 1'b1;
            end
        end
    end

    assign bus.i_req_ready = gnt_i;
    assign bus.d_req_ready = gnt_d;

    // Round-robin pointer moves only when both ports competed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_d <= 1'b1;
        end else if (contend) begin
            prio_d <= gnt_i;
        end
    end

    // Byte-lane store at the grant edge; illegal addresses never touch the array.
    always_ff @(posedge clk) begin
        if (gnt_d && bus.d_we && d_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.d_be[k]) begin
                    mem[d_idx][8*k +: 8] <= bus.d_wdata[8*k +: 8];
                end
            end
        end
    end

    // Registered responses; reads see the array as it was before this edge.
    logic              i_vld_q;
    logic              i_err_q;
    logic [DATA_W-1:0] i_dat_q;
    logic              d_vld_q;
    logic              d_err_q;
    logic [DATA_W-1:0] d_dat_q;

    // Capture one response per grant; stores and errors return zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_vld_q <= 1'b0;
            i_err_q <= 1'b0;
            i_dat_q <= '0;
            d_vld_q <= 1'b0;
            d_err_q <= 1'b0;
            d_dat_q <= '0;
        end else begin
            i_vld_q <= gnt_i;
            i_err_q <= gnt_i & ~i_ok;
            i_dat_q <= (gnt_i && i_ok) ? mem[i_idx] : '0;
            d_vld_q <= gnt_d;
            d_err_q <= gnt_d & ~d_ok;
            d_dat_q <= (gnt_d && d_ok && !bus.d_we) ? mem[d_idx] : '0;
        end
    end

    // A response falling due in a cycle that has reset asserted is dropped
    // rather than presented, so the consumer never sees it.
    assign bus.i_rsp_valid = i_vld_q & rst_n;
    assign bus.i_err       = i_err_q & rst_n;
    assign bus.i_rdata     = rst_n ? i_dat_q : '0;
    assign bus.d_rsp_valid = d_vld_q & rst_n;
    assign bus.d_err       = d_err_q & rst_n;
    assign bus.d_rdata     = rst_n ? d_dat_q : '0;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Bench for unified_mem_arb: directed requests checked against a transaction-level memory model.
// Latency: model predicts each response one cycle after its grant.
// Backpressure: requests are held until granted; responses are observed every cycle.
module tb_unified_mem_arb;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    unified_mem_arb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .INIT_FILE("")
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mm [DEPTH];
    bit          d_lost_last = 1'b1;   // reset behaves as if data lost, so data wins first
    bit          e_iv = 0, e_ie = 0, e_dv = 0, e_de = 0;
    logic [31:0] e_id = '0, e_dd = '0;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && ((a >> 2) < DEPTH);
    endfunction

    function automatic void arb(input logic iv, input logic dv, input logic rst,
                                input bit d_first, output bit gi, output bit gd);
        gi = 0;
        gd = 0;
        if (rst) begin
            if (iv && dv) begin
                gd = d_first;
                gi = !d_first;
            end else begin
                gi = iv;
                gd = dv;
            end
        end
    endfunction

    always @(posedge clk) begin : model
        bit          gi, gd;
        int          idx;
        logic [31:0] w;
        arb(bus.i_req_valid, bus.d_req_valid, rst_n, d_lost_last, gi, gd);
        if (!rst_n) begin
            d_lost_last = 1'b1;
            e_iv = 0; e_ie = 0; e_id = '0;
            e_dv = 0; e_de = 0; e_dd = '0;
        end else begin
            if (bus.i_req_valid && bus.d_req_valid) d_lost_last = gi;
            e_iv = gi; e_ie = 0; e_id = '0;
            if (gi) begin
                if (legal(bus.i_addr)) e_id = mm[int'(bus.i_addr >> 2)];
                else                   e_ie = 1;
            end
            e_dv = gd; e_de = 0; e_dd = '0;
            if (gd) begin
                if (!legal(bus.d_addr)) begin
                    e_de = 1;
                end else begin
                    idx = int'(bus.d_addr >> 2);
                    if (bus.d_we) begin
                        w = mm[idx];
                        for (int k = 0; k < 4; k++)
                            if (bus.d_be[k]) w[8*k +: 8] = bus.d_wdata[8*k +: 8];
                        mm[idx] = w;
                    end else begin
                        e_dd = mm[idx];
                    end
                end
            end
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        bit gi, gd;
        arb(bus.i_req_valid, bus.d_req_valid, rst_n, d_lost_last, gi, gd);
        chk("i_req_ready", {31'b0, bus.i_req_ready}, {31'b0, gi});
        chk("d_req_ready", {31'b0, bus.d_req_ready}, {31'b0, gd});
        chk("i_rsp_valid", {31'b0, bus.i_rsp_valid}, {31'b0, e_iv & rst_n});
        chk("d_rsp_valid", {31'b0, bus.d_rsp_valid}, {31'b0, e_dv & rst_n});
        if (e_iv && rst_n) begin
            chk("i_err",   {31'b0, bus.i_err}, {31'b0, e_ie});
            chk("i_rdata", bus.i_rdata, e_id);
        end
        if (e_dv && rst_n) begin
            chk("d_err",   {31'b0, bus.d_err}, {31'b0, e_de});
            chk("d_rdata", bus.d_rdata, e_dd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_req(input logic iv, input logic [31:0] ia, input logic dv,
                           input logic [31:0] da, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
        bus.i_req_valid = iv;
        bus.i_addr      = ia;
        bus.d_req_valid = dv;
        bus.d_addr      = da;
        bus.d_we        = we;
        bus.d_be        = be;
        bus.d_wdata     = wd;
    endtask

    task automatic idle();                     set_req(0, 0, 0, 0, 0, 4'h0, 0); endtask
    task automatic dst(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        set_req(0, 0, 1, a, 1, be, wd);
    endtask
    task automatic dld(input logic [31:0] a);   set_req(0, 0, 1, a, 0, 4'h0, 0); endtask
    task automatic fetch(input logic [31:0] a); set_req(1, a, 0, 0, 0, 4'h0, 0); endtask
    task automatic tick(); @(posedge clk); #1; endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick(); tick();
        chk("rst i_rsp_valid", {31'b0, bus.i_rsp_valid}, 32'd0);
        chk("rst i_err",       {31'b0, bus.i_err},       32'd0);
        chk("rst i_rdata",     bus.i_rdata,              32'd0);
        chk("rst d_rsp_valid", {31'b0, bus.d_rsp_valid}, 32'd0);
        chk("rst d_err",       {31'b0, bus.d_err},       32'd0);
        chk("rst d_rdata",     bus.d_rdata,              32'd0);
        rst_n = 1'b1;

        // Preload through the store port.
        dst(0,  4'hF, 32'h0123_4567); tick();
        dst(16, 4'hF, 32'h0000_000F); tick();
        dst(20, 4'hF, 32'h1122_3344); tick();

        dld(16); tick();
        chk("load16 valid", {31'b0, bus.d_rsp_valid}, 32'd1);
        chk("load16 data",  bus.d_rdata,              32'h0000_000F);
        chk("load16 err",   {31'b0, bus.d_err},       32'd0);

        dst(20, 4'b0101, 32'hAABB_CCDD); tick();
        chk("store rdata zero", bus.d_rdata,              32'd0);
        chk("store valid",      {31'b0, bus.d_rsp_valid}, 32'd1);
        dld(20); tick();
        chk("byte merge", bus.d_rdata, 32'h11BB_33DD);

        dst(8, 4'hF, 32'hDEAD_BEEF); tick();
        dld(8); tick();
        chk("store->load bypass", bus.d_rdata, 32'hDEAD_BEEF);

        dst(4*DEPTH, 4'hF, 32'hFFFF_FFFF); tick();
        chk("oob store err",   {31'b0, bus.d_err}, 32'd1);
        chk("oob store rdata", bus.d_rdata,        32'd0);
        dst(18, 4'hF, 32'hFFFF_FFFF); tick();
        chk("misaligned err",  {31'b0, bus.d_err}, 32'd1);
        dst(16, 4'h0, 32'hFFFF_FFFF); tick();
        chk("be0 valid", {31'b0, bus.d_rsp_valid}, 32'd1);
        chk("be0 err",   {31'b0, bus.d_err},       32'd0);
        dld(0);  tick();
        chk("word0 intact",  bus.d_rdata, 32'h0123_4567);
        dld(16); tick();
        chk("word4 intact",  bus.d_rdata, 32'h0000_000F);

        fetch(2); tick();
        chk("fetch misaligned err", {31'b0, bus.i_err}, 32'd1);
        fetch(4*DEPTH + 4); tick();
        chk("fetch oob err",        {31'b0, bus.i_err}, 32'd1);
        chk("fetch oob rdata",      bus.i_rdata,        32'd0);
        fetch(20); tick();
        chk("fetch data",           bus.i_rdata,        32'h11BB_33DD);
        idle(); tick();
        chk("idle no i rsp", {31'b0, bus.i_rsp_valid}, 32'd0);
        chk("idle no d rsp", {31'b0, bus.d_rsp_valid}, 32'd0);

        // Contention from reset: D, I, D, I.
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        set_req(1, 16, 1, 8, 0, 4'h0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr d_ready", {31'b0, bus.d_req_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr i_ready", {31'b0, bus.i_req_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr d_rsp", {31'b0, bus.d_rsp_valid}, (c % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr i_rsp", {31'b0, bus.i_rsp_valid}, (c % 2 == 1) ? 32'd1 : 32'd0);
        end
        // A lone fetch does not move the round-robin pointer.
        fetch(16); tick();
        set_req(1, 16, 1, 8, 0, 4'h0, 0); #1;
        chk("rr after solo", {31'b0, bus.d_req_ready}, 32'd1);
        tick(); #1;
        chk("rr next i", {31'b0, bus.i_req_ready}, 32'd1);
        tick();

        // Reset right after a fetch grant drops its response.
        idle(); tick();
        fetch(20); #1;
        chk("pre-rst grant", {31'b0, bus.i_req_ready}, 32'd1);
        tick();
        rst_n = 1'b0;
        set_req(0, 0, 1, 16, 0, 4'h0, 0); #1;
        chk("rst drops rsp",   {31'b0, bus.i_rsp_valid}, 32'd0);
        chk("rst blocks req",  {31'b0, bus.d_req_ready}, 32'd0);
        tick();
        idle(); tick();
        rst_n = 1'b1;
        fetch(20); tick();
        chk("post-rst valid", {31'b0, bus.i_rsp_valid}, 32'd1);
        chk("post-rst data",  bus.i_rdata,              32'h11BB_33DD);

        idle(); tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
